seg7_readback: RTL and testbench

- Decodes the six 8-bit seven-segment digit codes driven by the ALU display stage back into a 6-bit integer; it is the decoder for that display encoder.
- Used as an on-chip self-check: the readback value is compared against the ALU result, and the comparison also runs in the simulation scoreboard.
- Supports two formats:
  - Binary: six digits, one bit per digit, each digit showing a 0/1 glyph.
  - Decimal: two digits, tens on seg1 and ones on seg0.

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_glyph_dec.sv | 35 +++
 rtl/seg7_readback.sv | 160 ++++++++++++++++
 tb/tb_seg7_readback.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph patterns (bit6..0 = segments a..g),
// display mode and readback FSM state types.
package seg7_pkg;

  localparam int SEG_NDIG    = 6;
  localparam int SEG_DEC_MAX = 63;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    MODE_BIN = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Forward glyph lookup for the display encoder side.
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0:    seg_glyph = SEG_0;
      4'd1:    seg_glyph = SEG_1;
      4'd2:    seg_glyph = SEG_2;
      4'd3:    seg_glyph = SEG_3;
      4'd4:    seg_glyph = SEG_4;
      4'd5:    seg_glyph = SEG_5;
      4'd6:    seg_glyph = SEG_6;
      4'd7:    seg_glyph = SEG_7;
      4'd8:    seg_glyph = SEG_8;
      4'd9:    seg_glyph = SEG_9;
      default: seg_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational reverse glyph lookup: 7-bit segment pattern to digit value,
// with separate flags for a legal digit and a blank.
module seg7_glyph_dec
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       is_digit,
  output logic       is_blank,
  output logic [3:0] digit
);

  always_comb begin
    is_digit = 1'b1;
    is_blank = 1'b0;
    digit    = 4'd0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Decodes six snapshotted seven-segment digits back into a 6-bit value,
// one digit per clock. Optional macro SEG7_DP_CHECK_EN flags any set dp bit.
//
// state   | meaning
// IDLE    | waiting for start; snapshot taken on the accepting edge
// SCAN    | evaluating snapshot digit idx, 5 down to 0
// DONE    | register value/err/err_idx and pulse done
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int NDIG    = SEG_NDIG,
  parameter int DEC_MAX = SEG_DEC_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  input  logic [7:0] seg3,
  input  logic [7:0] seg4,
  input  logic [7:0] seg5,
  output logic       busy,
  output logic       done,
  output logic [5:0] value,
  output logic       err,
  output logic [2:0] err_idx
);

  localparam logic [6:0] DEC_MAX_W = 7'(DEC_MAX);
  localparam logic [2:0] IDX_TOP   = 3'(NDIG - 1);

  state_e      state_q, state_d;
  mode_e       mode_q;
  logic [7:0]  snap_q [NDIG];
  logic [2:0]  idx_q;
  logic [6:0]  acc_q, acc_d;
  logic        err_flag_q;
  logic [2:0]  first_idx_q;
  logic        done_q, err_q;
  logic [5:0]  value_q;
  logic [2:0]  err_idx_q;

  logic [7:0]  cur_digit;
  logic        g_is_digit, g_is_blank;
  logic [3:0]  g_digit;
  logic        dig_bad;
  logic        ovf, err_d;

  assign cur_digit = snap_q[idx_q];

  seg7_glyph_dec u_glyph_dec (
    .pattern  (cur_digit[6:0]),
    .is_digit (g_is_digit),
    .is_blank (g_is_blank),
    .digit    (g_digit)
  );

  always_comb begin
    dig_bad = 1'b0;
    acc_d   = acc_q;
    if (mode_q == MODE_BIN) begin
      if (g_is_blank) begin
        acc_d = {acc_q[5:0], 1'b0};
      end else if (g_is_digit && (g_digit <= 4'd1)) begin
        acc_d = {acc_q[5:0], g_digit[0]};
      end else begin
        dig_bad = 1'b1;
        acc_d   = {acc_q[5:0], 1'b0};
      end
    end else if (idx_q >= 3'd2) begin
      // Upper decimal digits carry no value; they must simply be dark.
      dig_bad = !g_is_blank;
    end else begin
      dig_bad = !g_is_digit;
      acc_d   = acc_q * 7'd10 + {3'b000, g_digit};
    end
`ifdef SEG7_DP_CHECK_EN
    if (cur_digit[7]) dig_bad = 1'b1;
`endif
  end

`ifndef SEG7_DP_CHECK_EN
  logic unused_dp;
  assign unused_dp = cur_digit[7];
`endif

  assign ovf   = (mode_q == MODE_DEC) && (acc_q > DEC_MAX_W);
  assign err_d = err_flag_q || ovf;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (idx_q == 3'd0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_BIN;
      idx_q       <= 3'd0;
      acc_q       <= 7'd0;
      err_flag_q  <= 1'b0;
      first_idx_q <= 3'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      value_q     <= 6'd0;
      err_idx_q   <= 3'd0;
      for (int i = 0; i < NDIG; i++) snap_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap_q[0]   <= seg0;
            snap_q[1]   <= seg1;
            snap_q[2]   <= seg2;
            snap_q[3]   <= seg3;
            snap_q[4]   <= seg4;
            snap_q[5]   <= seg5;
            mode_q      <= mode_e'(mode);
            idx_q       <= IDX_TOP;
            acc_q       <= 7'd0;
            err_flag_q  <= 1'b0;
            first_idx_q <= 3'd0;
          end
        end
        ST_SCAN: begin
          acc_q <= acc_d;
          idx_q <= idx_q - 3'd1;
          if (dig_bad && !err_flag_q) begin
            err_flag_q  <= 1'b1;
            first_idx_q <= idx_q;
          end
        end
        ST_DONE: begin
          done_q    <= 1'b1;
          err_q     <= err_d;
          value_q   <= err_d ? 6'd0 : acc_q[5:0];
          // Digit errors win; a pure decimal overflow points at the tens digit.
          err_idx_q <= err_flag_q ? first_idx_q : (ovf ? 3'd1 : 3'd0);
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q == ST_SCAN);
  assign done    = done_q;
  assign value   = value_q;
  assign err     = err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Directed table-driven bench for seg7_readback plus hand sequences for
// held start, snapshotting and reset during a scan.
module tb_seg7_readback;
  import seg7_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, mode;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;
  logic       busy, done, err;
  logic [5:0] value;
  logic [2:0] err_idx;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] B  = {1'b0, SEG_BLANK};
  localparam logic [7:0] G0 = {1'b0, SEG_0};
  localparam logic [7:0] G1 = {1'b0, SEG_1};
  localparam logic [7:0] G2 = {1'b0, SEG_2};
  localparam logic [7:0] G3 = {1'b0, SEG_3};
  localparam logic [7:0] G4 = {1'b0, SEG_4};
  localparam logic [7:0] G5 = {1'b0, SEG_5};
  localparam logic [7:0] G6 = {1'b0, SEG_6};
  localparam logic [7:0] G8 = {1'b0, SEG_8};
  localparam logic [7:0] G9 = {1'b0, SEG_9};
  localparam logic [7:0] JUNK = 8'b0000_0001;

  typedef struct {
    logic             m;
    logic [5:0][7:0]  s;     // s[5] = seg5 ... s[0] = seg0
    int               ev;
    int               ee;
    int               ei;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  seg7_readback dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .seg0    (seg0),
    .seg1    (seg1),
    .seg2    (seg2),
    .seg3    (seg3),
    .seg4    (seg4),
    .seg5    (seg5),
    .busy    (busy),
    .done    (done),
    .value   (value),
    .err     (err),
    .err_idx (err_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_segs(input logic [5:0][7:0] s);
    seg5 = s[5]; seg4 = s[4]; seg3 = s[3];
    seg2 = s[2]; seg1 = s[1]; seg0 = s[0];
  endtask

  // One decode; inputs are inverted right after the start edge so any
  // dependence on live inputs instead of the snapshot shows up.
  task automatic decode(input logic m, input logic [5:0][7:0] s,
                        output int lat, output int bcnt);
    @(negedge clk);
    mode = m; set_segs(s); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mode = ~m; set_segs(~s);
    bcnt = int'(busy);
    lat  = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      bcnt += int'(busy);
    end
  endtask

  initial begin
    int lat, bcnt, ndone, first_k, second_k;
    logic [5:0] v1, v2;

    vecs[0]  = '{1'b1, {B, B, B, B, G4, G2}, 42, 0, 0};
    vecs[1]  = '{1'b1, {B, B, B, B, G6, G4}, 0, 1, 1};
    vecs[2]  = '{1'b1, {B, B, B, B, G6, G3}, 63, 0, 0};
    vecs[3]  = '{1'b0, {G1, G0, G1, G0, G1, G1}, 43, 0, 0};
    vecs[4]  = '{1'b0, {B, B, B, G1, G1, G0}, 6, 0, 0};
    vecs[5]  = '{1'b0, {G0, G1, G2, G0, JUNK, G1}, 0, 1, 3};
    vecs[6]  = '{1'b1, {B, B, B, B, G0, G0}, 0, 0, 0};
    vecs[7]  = '{1'b1, {B, B, B, B, B, G5}, 0, 1, 1};
    vecs[8]  = '{1'b1, {B, G1, B, B, G4, G2}, 0, 1, 4};
    vecs[9]  = '{1'b1, {B, B, B, B, G9, G9}, 0, 1, 1};
    vecs[10] = '{1'b0, {B, B, B, B, B, B}, 0, 0, 0};
    vecs[11] = '{1'b0, {G1, G1, G1, G1, G1, G1}, 63, 0, 0};
    vecs[12] = '{1'b1, {G8, B, B, B, G3, B}, 0, 1, 5};
`ifdef SEG7_DP_CHECK_EN
    vecs[13] = '{1'b1, {B, B, B, B, G4, G2 | 8'h80}, 0, 1, 0};
`else
    vecs[13] = '{1'b1, {B, B, B, B, G4, G2 | 8'h80}, 42, 0, 0};
`endif

    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    set_segs('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_idx", int'(err_idx), 0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      decode(vecs[i].m, vecs[i].s, lat, bcnt);
      chk($sformatf("v%0d_latency", i), lat, 7);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, 6);
      chk($sformatf("v%0d_value", i), int'(value), vecs[i].ev);
      chk($sformatf("v%0d_err", i), int'(err), vecs[i].ee);
      chk($sformatf("v%0d_err_idx", i), int'(err_idx), vecs[i].ei);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
      if (i == 0) begin
        repeat (3) @(negedge clk);
        chk("hold_value", int'(value), 42);
        chk("hold_busy", int'(busy), 0);
      end
    end

    // Held start: snapshot isolation, one done per accepted start,
    // re-accept on the edge after done.
    @(negedge clk);
    mode = 1'b1; set_segs({B, B, B, B, G4, G2}); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_segs({B, B, B, B, G6, G3});
    ndone = 0; first_k = -1; second_k = -1; v1 = '0; v2 = '0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 8) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin first_k = k; v1 = value; end
        if (ndone == 2) begin second_k = k; v2 = value; end
      end
    end
    chk("held_done_count", ndone, 2);
    chk("held_first_latency", first_k, 7);
    chk("held_second_latency", second_k, 15);
    chk("held_first_value", int'(v1), 42);
    chk("held_second_value", int'(v2), 63);

    // Reset asserted while idx 2 is being processed.
    @(negedge clk);
    mode = 1'b1; set_segs({B, B, B, B, G4, G2}); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_value", int'(value), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_err_idx", int'(err_idx), 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);

    decode(1'b0, {G1, G0, G1, G0, G1, G1}, lat, bcnt);
    chk("post_rst_latency", lat, 7);
    chk("post_rst_value", int'(value), 43);
    chk("post_rst_err", int'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
